// File: rtl/pulse_seq_multi_if.sv
// Bus bundle for the multi-channel pulse sequencer: triggers and config in, pulses and status out.
interface pulse_seq_multi_if #(
  parameter int unsigned NumCh     = 4,
  parameter int unsigned CntW      = 24,
  parameter int unsigned ScanSteps = 16
);
  localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned IdxW = $clog2(ScanSteps);

  logic             trig;
  logic             scan_trig;
  logic             cfg_we;
  logic [ChW-1:0]   cfg_ch;
  logic [1:0]       cfg_sel;
  logic [CntW-1:0]  cfg_data;
  logic [NumCh-1:0] pulse;
  logic             busy;
  logic [IdxW-1:0]  scan_idx;
  logic             overrun;

  modport master (
    output trig, scan_trig, cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  pulse, busy, scan_idx, overrun
  );

  modport slave (
    input  trig, scan_trig, cfg_we, cfg_ch, cfg_sel, cfg_data,
    output pulse, busy, scan_idx, overrun
  );
endinterface

// File: rtl/pulse_seq_multi.sv
// Trigger-driven multi-channel pulse sequencer with programmable delay/width and a
// scan trigger that steps each channel's width by a per-channel increment.
module pulse_seq_multi #(
  parameter int unsigned NumCh     = 4,
  parameter int unsigned CntW      = 24,
  parameter int unsigned ScanSteps = 16
) (
  input logic              clk,
  input logic              rst,
  pulse_seq_multi_if.slave bus
);
  localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned IdxW = $clog2(ScanSteps);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ScanSteps - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StPulse} state_e;

  logic [2:0]       trig_sync_q, scan_sync_q;
  logic             trig_edge_q, scan_edge_q;
  logic [CntW-1:0]  delay_q  [NumCh];
  logic [CntW-1:0]  width_q  [NumCh];
  logic [CntW-1:0]  step_q   [NumCh];
  logic [CntW-1:0]  offset_q [NumCh];
  logic [CntW-1:0]  cnt_q    [NumCh];
  logic [CntW-1:0]  wlat_q   [NumCh];
  logic [CntW-1:0]  eff_w    [NumCh];
  state_e           state_q  [NumCh];
  logic [NumCh-1:0] mask_q, pulse_q;
  logic [IdxW-1:0]  idx_q;
  logic             overrun_q, busy, any_edge, shot, scan_shot;

  function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a, input logic [CntW-1:0] b);
    logic [CntW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CntW] ? '1 : s[CntW-1:0];
  endfunction

  always_comb begin
    busy = 1'b0;
    for (int c = 0; c < NumCh; c++) begin
      if (state_q[c] != StIdle) busy = 1'b1;
      eff_w[c] = scan_edge_q ? sat_add(width_q[c], offset_q[c]) : width_q[c];
    end
  end

  // A simultaneous plain edge is absorbed by the scan shot.
  assign any_edge  = trig_edge_q | scan_edge_q;
  assign shot      = any_edge & ~busy;
  assign scan_shot = shot & scan_edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_sync_q <= '0;
      scan_sync_q <= '0;
      trig_edge_q <= 1'b0;
      scan_edge_q <= 1'b0;
      mask_q      <= '0;
      pulse_q     <= '0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
      for (int c = 0; c < NumCh; c++) begin
        delay_q[c]  <= '0;
        width_q[c]  <= '0;
        step_q[c]   <= '0;
        offset_q[c] <= '0;
        cnt_q[c]    <= '0;
        wlat_q[c]   <= '0;
        state_q[c]  <= StIdle;
      end
    end else begin
      trig_sync_q <= {trig_sync_q[1:0], bus.trig};
      scan_sync_q <= {scan_sync_q[1:0], bus.scan_trig};
      trig_edge_q <= trig_sync_q[1] & ~trig_sync_q[2];
      scan_edge_q <= scan_sync_q[1] & ~scan_sync_q[2];

      for (int c = 0; c < NumCh; c++) begin
        unique case (state_q[c])
          StIdle: begin
            if (shot && mask_q[c]) begin
              wlat_q[c] <= eff_w[c];
              if (delay_q[c] != '0) begin
                state_q[c] <= StDelay;
                cnt_q[c]   <= delay_q[c] - CntW'(1);
              end else if (eff_w[c] != '0) begin
                state_q[c] <= StPulse;
                cnt_q[c]   <= eff_w[c] - CntW'(1);
                pulse_q[c] <= 1'b1;
              end
            end
          end
          StDelay: begin
            if (cnt_q[c] != '0) begin
              cnt_q[c] <= cnt_q[c] - CntW'(1);
            end else if (wlat_q[c] != '0) begin
              state_q[c] <= StPulse;
              cnt_q[c]   <= wlat_q[c] - CntW'(1);
              pulse_q[c] <= 1'b1;
            end else begin
              state_q[c] <= StIdle;
            end
          end
          StPulse: begin
            if (cnt_q[c] != '0) begin
              cnt_q[c] <= cnt_q[c] - CntW'(1);
            end else begin
              state_q[c] <= StIdle;
              pulse_q[c] <= 1'b0;
            end
          end
          default: begin
            state_q[c] <= StIdle;
            pulse_q[c] <= 1'b0;
          end
        endcase
      end

      if (scan_shot) begin
        if (idx_q == LastIdx) begin
          idx_q <= '0;
          for (int c = 0; c < NumCh; c++) offset_q[c] <= '0;
        end else begin
          idx_q <= idx_q + IdxW'(1);
          for (int c = 0; c < NumCh; c++) offset_q[c] <= sat_add(offset_q[c], step_q[c]);
        end
      end

      // Writes land after the shot latch, so a coinciding shot sees the old values.
      if (bus.cfg_we) begin
        unique case (bus.cfg_sel)
          2'd0: for (int c = 0; c < NumCh; c++) begin
            if (ChW'(c) == bus.cfg_ch) delay_q[c] <= bus.cfg_data;
          end
          2'd1: for (int c = 0; c < NumCh; c++) begin
            if (ChW'(c) == bus.cfg_ch) width_q[c] <= bus.cfg_data;
          end
          2'd2: for (int c = 0; c < NumCh; c++) begin
            if (ChW'(c) == bus.cfg_ch) step_q[c] <= bus.cfg_data;
          end
          default: begin
            mask_q <= bus.cfg_data[NumCh-1:0];
            idx_q  <= '0;
            for (int c = 0; c < NumCh; c++) offset_q[c] <= '0;
          end
        endcase
      end

      if (any_edge && busy) begin
        overrun_q <= 1'b1;
      end else if (bus.cfg_we && bus.cfg_sel == 2'd3) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.pulse    = pulse_q;
  assign bus.busy     = busy;
  assign bus.scan_idx = idx_q;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_pulse_seq_multi.sv
// Self-checking bench for pulse_seq_multi: directed scenarios plus randomized shots
// checked against a shot-level reference model.
module tb_pulse_seq_multi;
  localparam int unsigned NumCh     = 4;
  localparam int unsigned CntW      = 8;
  localparam int unsigned ScanSteps = 4;
  localparam int unsigned IdxW      = 2;
  localparam int          MaxCnt    = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_seq_multi_if #(.NumCh(NumCh), .CntW(CntW), .ScanSteps(ScanSteps)) bus ();
  pulse_seq_multi #(.NumCh(NumCh), .CntW(CntW), .ScanSteps(ScanSteps)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state
  int m_delay [NumCh];
  int m_width [NumCh];
  int m_step  [NumCh];
  int m_off   [NumCh];
  int m_mask, m_idx;
  bit m_ovr;

  // Expected and observed shot results (cycles relative to the sampling edge of the trigger)
  int exp_first [NumCh];
  int exp_cnt   [NumCh];
  int exp_bfirst, exp_bcnt;
  int obs_first [NumCh];
  int obs_cnt   [NumCh];
  int obs_bfirst, obs_bcnt;

  task automatic model_reset();
    for (int c = 0; c < NumCh; c++) begin
      m_delay[c] = 0; m_width[c] = 0; m_step[c] = 0; m_off[c] = 0;
    end
    m_mask = 0; m_idx = 0; m_ovr = 1'b0;
  endtask

  task automatic model_shot(input bit scan);
    int span;
    int w;
    span = 0;
    for (int c = 0; c < NumCh; c++) begin
      w = m_width[c];
      if (scan) w = (m_width[c] + m_off[c] > MaxCnt) ? MaxCnt : m_width[c] + m_off[c];
      if (m_mask[c] && w > 0) begin
        exp_first[c] = 3 + m_delay[c];
        exp_cnt[c]   = w;
      end else begin
        exp_first[c] = -1;
        exp_cnt[c]   = 0;
      end
      if (m_mask[c] && m_delay[c] + w > span) span = m_delay[c] + w;
    end
    exp_bfirst = (span > 0) ? 3 : -1;
    exp_bcnt   = span;
    if (scan) begin
      if (m_idx == ScanSteps - 1) begin
        m_idx = 0;
        for (int c = 0; c < NumCh; c++) m_off[c] = 0;
      end else begin
        m_idx++;
        for (int c = 0; c < NumCh; c++)
          m_off[c] = (m_off[c] + m_step[c] > MaxCnt) ? MaxCnt : m_off[c] + m_step[c];
      end
    end
  endtask

  task automatic cfg(input int ch, input int sel, input int data);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = ch[1:0];
    bus.cfg_sel  = sel[1:0];
    bus.cfg_data = data[CntW-1:0];
    @(negedge clk);
    bus.cfg_we = 1'b0;
    case (sel)
      0: m_delay[ch] = data;
      1: m_width[ch] = data;
      2: m_step[ch]  = data;
      default: begin
        m_mask = data & ((1 << NumCh) - 1);
        m_idx  = 0;
        m_ovr  = 1'b0;
        for (int c = 0; c < NumCh; c++) m_off[c] = 0;
      end
    endcase
  endtask

  // Fire trigger(s) and record pulse/busy activity for `window` cycles.
  task automatic run_shot(input bit plain, input bit scan, input int retrig_at, input int window);
    for (int c = 0; c < NumCh; c++) begin
      obs_first[c] = -1; obs_cnt[c] = 0;
    end
    obs_bfirst = -1; obs_bcnt = 0;
    @(negedge clk);
    bus.trig = plain;
    bus.scan_trig = scan;
    for (int j = 0; j < window; j++) begin
      @(negedge clk);
      for (int c = 0; c < NumCh; c++) begin
        if (bus.pulse[c] === 1'b1) begin
          if (obs_first[c] < 0) obs_first[c] = j;
          obs_cnt[c]++;
        end
      end
      if (bus.busy === 1'b1) begin
        if (obs_bfirst < 0) obs_bfirst = j;
        obs_bcnt++;
      end
      bus.trig = (j == retrig_at);
      bus.scan_trig = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pulse !== '0 || bus.busy !== 1'b0 || bus.scan_idx !== '0 || bus.overrun !== 1'b0)
      $display("FAIL reset: pulse=%b busy=%b idx=%0d ovr=%b, want all zero",
               bus.pulse, bus.busy, bus.scan_idx, bus.overrun);
    else passed++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    cfg(0, 0, 5); cfg(0, 1, 10); cfg(0, 3, 1);
    model_shot(1'b0);
    run_shot(1'b1, 1'b0, -1, exp_bcnt + 8);
    for (int c = 0; c < NumCh; c++) begin
      checks++;
      if (obs_first[c] !== exp_first[c] || obs_cnt[c] !== exp_cnt[c])
        $display("FAIL basic ch%0d: first=%0d cnt=%0d, want first=%0d cnt=%0d",
                 c, obs_first[c], obs_cnt[c], exp_first[c], exp_cnt[c]);
      else passed++;
    end
    checks++;
    if (obs_bfirst !== exp_bfirst || obs_bcnt !== exp_bcnt)
      $display("FAIL basic busy: first=%0d cnt=%0d, want first=%0d cnt=%0d",
               obs_bfirst, obs_bcnt, exp_bfirst, exp_bcnt);
    else passed++;
  endtask

  task automatic test_scan();
    cfg(0, 0, 0); cfg(0, 1, 4); cfg(0, 2, 2); cfg(0, 3, 1);
    for (int s = 0; s < 5; s++) begin
      model_shot(1'b1);
      run_shot(1'b0, 1'b1, -1, exp_bcnt + 8);
      checks++;
      if (obs_first[0] !== exp_first[0] || obs_cnt[0] !== exp_cnt[0] ||
          bus.scan_idx !== IdxW'(m_idx))
        $display("FAIL scan shot%0d: first=%0d width=%0d idx=%0d, want first=%0d width=%0d idx=%0d",
                 s, obs_first[0], obs_cnt[0], bus.scan_idx, exp_first[0], exp_cnt[0], m_idx);
      else passed++;
    end
  endtask

  task automatic test_overrun();
    cfg(0, 0, 0); cfg(0, 1, 20); cfg(0, 3, 1);
    model_shot(1'b0);
    run_shot(1'b1, 1'b0, 1, exp_bcnt + 8);
    m_ovr = 1'b1;
    checks++;
    if (obs_first[0] !== exp_first[0] || obs_cnt[0] !== exp_cnt[0] || obs_bcnt !== exp_bcnt)
      $display("FAIL overrun pulse: first=%0d cnt=%0d busy=%0d, want first=%0d cnt=%0d busy=%0d",
               obs_first[0], obs_cnt[0], obs_bcnt, exp_first[0], exp_cnt[0], exp_bcnt);
    else passed++;
    checks++;
    if (bus.overrun !== m_ovr) $display("FAIL overrun set: got %b want %b", bus.overrun, m_ovr);
    else passed++;
    cfg(0, 3, 1);
    checks++;
    if (bus.overrun !== m_ovr) $display("FAIL overrun clear: got %b want %b", bus.overrun, m_ovr);
    else passed++;
  endtask

  task automatic test_both_edges();
    cfg(0, 0, 2); cfg(0, 1, 5); cfg(0, 2, 3); cfg(0, 3, 1);
    for (int s = 0; s < 2; s++) begin
      model_shot(1'b1);
      run_shot(1'b1, 1'b1, -1, exp_bcnt + 8);
      checks++;
      if (obs_first[0] !== exp_first[0] || obs_cnt[0] !== exp_cnt[0] ||
          bus.scan_idx !== IdxW'(m_idx) || bus.overrun !== m_ovr)
        $display("FAIL both_edges shot%0d: first=%0d w=%0d idx=%0d ovr=%b, want %0d %0d %0d %b",
                 s, obs_first[0], obs_cnt[0], bus.scan_idx, bus.overrun,
                 exp_first[0], exp_cnt[0], m_idx, m_ovr);
      else passed++;
    end
  endtask

  task automatic test_mask();
    cfg(0, 0, 1); cfg(0, 1, 7);
    cfg(1, 0, 0); cfg(1, 1, 0);
    cfg(2, 0, 0); cfg(2, 1, 3);
    cfg(3, 0, 2); cfg(3, 1, 4);
    cfg(0, 3, 6);
    model_shot(1'b0);
    run_shot(1'b1, 1'b0, -1, exp_bcnt + 8);
    for (int c = 0; c < NumCh; c++) begin
      checks++;
      if (obs_first[c] !== exp_first[c] || obs_cnt[c] !== exp_cnt[c])
        $display("FAIL mask ch%0d: first=%0d cnt=%0d, want first=%0d cnt=%0d",
                 c, obs_first[c], obs_cnt[c], exp_first[c], exp_cnt[c]);
      else passed++;
    end
    checks++;
    if (obs_bfirst !== exp_bfirst || obs_bcnt !== exp_bcnt)
      $display("FAIL mask busy: first=%0d cnt=%0d, want first=%0d cnt=%0d",
               obs_bfirst, obs_bcnt, exp_bfirst, exp_bcnt);
    else passed++;
  endtask

  task automatic test_saturate();
    cfg(0, 0, 0); cfg(0, 1, 200); cfg(0, 2, 100); cfg(0, 3, 1);
    for (int s = 0; s < 3; s++) begin
      model_shot(1'b1);
      run_shot(1'b0, 1'b1, -1, exp_bcnt + 8);
      checks++;
      if (obs_cnt[0] !== exp_cnt[0])
        $display("FAIL saturate shot%0d: width=%0d want %0d", s, obs_cnt[0], exp_cnt[0]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int ch, sel, nbad;
    bit scan;
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(1, 3)) begin
        ch  = $urandom_range(0, NumCh - 1);
        sel = $urandom_range(0, 3);
        case (sel)
          0: cfg(ch, 0, $urandom_range(0, 6));
          1: cfg(ch, 1, $urandom_range(0, 12));
          2: cfg(ch, 2, $urandom_range(0, 3));
          default: if ($urandom_range(0, 3) == 0) cfg(0, 3, $urandom_range(0, 15));
        endcase
      end
      scan = $urandom_range(0, 1);
      model_shot(scan);
      run_shot(~scan | ($urandom_range(0, 3) == 0), scan, -1, exp_bcnt + 8);
      nbad = 0;
      for (int c = 0; c < NumCh; c++)
        if (obs_first[c] !== exp_first[c] || obs_cnt[c] !== exp_cnt[c]) nbad++;
      checks++;
      if (nbad != 0 || obs_bcnt !== exp_bcnt || bus.scan_idx !== IdxW'(m_idx) ||
          bus.overrun !== m_ovr)
        $display("FAIL random it%0d: badch=%0d busy=%0d/%0d idx=%0d/%0d ovr=%b/%b (got/want)",
                 it, nbad, obs_bcnt, exp_bcnt, bus.scan_idx, m_idx, bus.overrun, m_ovr);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cfg(0, 0, 0); cfg(0, 1, 30); cfg(0, 3, 1);
    run_shot(1'b0, 1'b1, -1, 10);
    checks++;
    if (bus.pulse[0] !== 1'b1 || bus.scan_idx !== IdxW'(1))
      $display("FAIL reset_mid pre: pulse0=%b idx=%0d, want 1 and 1", bus.pulse[0], bus.scan_idx);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pulse !== '0 || bus.busy !== 1'b0 || bus.scan_idx !== '0 || bus.overrun !== 1'b0)
      $display("FAIL reset_mid: pulse=%b busy=%b idx=%0d ovr=%b, want all zero",
               bus.pulse, bus.busy, bus.scan_idx, bus.overrun);
    else passed++;
    rst = 1'b0;
    model_reset();
    cfg(0, 3, 1);
    model_shot(1'b0);
    run_shot(1'b1, 1'b0, -1, exp_bcnt + 8);
    checks++;
    if (obs_cnt[0] !== exp_cnt[0] || obs_bcnt !== exp_bcnt)
      $display("FAIL reset_mid config: width=%0d busy=%0d, want %0d %0d",
               obs_cnt[0], obs_bcnt, exp_cnt[0], exp_bcnt);
    else passed++;
  endtask

  initial begin
    bus.trig = 1'b0; bus.scan_trig = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
    test_reset();
    test_basic();
    test_scan();
    test_overrun();
    test_both_edges();
    test_mask();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
